// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between a pipeline stage and its neighbours.
// The upstream side (in_*) and the downstream side (out_*) travel together
// so one instance wires a stage to its producer and consumer.
interface pipe_stage_buf_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // Environment side: produces upstream beats and consumes downstream beats.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush and
// NOP-bubble insertion. in_ready is registered so downstream backpressure
// never reaches upstream combinationally; out_* come straight from flops.
module pipe_stage_buf #(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 128,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_buf_if.slave  bus,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic acc;
  logic drn;
  logic out_valid;

  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = bus.in_valid & in_ready_q;
  assign drn       = out_valid & bus.out_ready;

  // Next state of the buffer: flush wins over any handshake, then the
  // occupancy-driven moves between main and skid registers.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d     = ST_ONE;
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else if (acc) begin
            state_d     = ST_TWO;
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
          end else if (drn) begin
            // Bubble: control goes to NOP, payload is left as-is.
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end
        end
        ST_TWO: begin
          if (drn) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end

    // Ready for the next cycle follows the occupancy we are about to enter.
    in_ready_d = (state_d != ST_TWO);
  end

  // Saturating count of cycles where a beat is held against backpressure.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State and storage registers; reset clears everything and holds in_ready low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_data  = main_data_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, backpressure, flush,
// bubble, counter saturation and reset/flush against an accepted beat.
module tb_pipe_stage_buf;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic             clock;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] stall_cycles;

  int checks;
  int errors;

  pipe_stage_buf_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

  pipe_stage_buf #(
    .CTRL_W    (CTRL_W),
    .DATA_W    (DATA_W),
    .CLEAR_DATA(1'b1),
    .CNT_W     (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus.slave),
    .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison: count it, report a mismatch.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pay(input logic [CTRL_W-1:0] c);
    return 32'hD000_0000 | {24'h0, c};
  endfunction

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = pay(c);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h00);
    bus.in_data = 32'hFFFF_FFFF;

    // Reset values
    step();
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    reset = 1'b0;
    step();
    check("rst_rel_in_ready", 64'(bus.in_ready), 64'd1);

    // 1: full-rate stream 0x01..0x10
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i));
      step();
      check($sformatf("stream_ctrl_%0d", i), 64'(bus.out_ctrl), 64'(i));
      check($sformatf("stream_rdy_%0d", i), 64'(bus.in_ready), 64'd1);
    end
    check("stream_data_last", 64'(bus.out_data), 64'(pay(8'h10)));
    drive(1'b0, 8'h00);
    step();
    check("stream_end_valid", 64'(bus.out_valid), 64'd0);
    check("stream_stall", 64'(stall_cycles), 64'd0);

    // 2: backpressure into the skid register
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h01);
    step();
    check("bp_one_ctrl", 64'(bus.out_ctrl), 64'h01);
    drive(1'b1, 8'h02);
    step();
    check("bp_two_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 8'h00);
    step();
    step();
    check("bp_stall3", 64'(stall_cycles), 64'd3);
    check("bp_head_ctrl", 64'(bus.out_ctrl), 64'h01);
    bus.out_ready = 1'b1;
    #1;
    check("bp_drain_first", 64'(bus.out_ctrl), 64'h01);
    step();
    check("bp_drain_second", 64'(bus.out_ctrl), 64'h02);
    check("bp_drain_data", 64'(bus.out_data), 64'(pay(8'h02)));
    check("bp_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_stall_hold", 64'(stall_cycles), 64'd3);
    step();
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // 3: flush while two beats held, with 0x03 offered
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h01);
    step();
    drive(1'b1, 8'h02);
    step();
    check("fl_pre_stall", 64'(stall_cycles), 64'd4);
    check("fl_pre_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 8'h03);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("fl_out_valid", 64'(bus.out_valid), 64'd0);
    check("fl_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("fl_out_data", 64'(bus.out_data), 64'd0);
    check("fl_in_ready", 64'(bus.in_ready), 64'd1);
    check("fl_stall", 64'(stall_cycles), 64'd4);
    flush = 1'b0;
    drive(1'b0, 8'h00);
    step();
    check("fl_no_03_valid", 64'(bus.out_valid), 64'd0);
    check("fl_no_03_ctrl", 64'(bus.out_ctrl), 64'd0);

    // 4: bubble keeps payload, zeroes control
    drive(1'b1, 8'h55);
    step();
    check("bub_ctrl", 64'(bus.out_ctrl), 64'h55);
    drive(1'b0, 8'h00);
    step();
    check("bub_valid", 64'(bus.out_valid), 64'd0);
    check("bub_ctrl0", 64'(bus.out_ctrl), 64'd0);
    check("bub_data", 64'(bus.out_data), 64'(pay(8'h55)));

    // 5: stall counter saturation, then reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h77);
    step();
    drive(1'b0, 8'h00);
    for (int i = 0; i < 20; i++) step();
    check("sat_stall", 64'(stall_cycles), 64'd15);
    check("sat_head", 64'(bus.out_ctrl), 64'h77);
    reset = 1'b1;
    step();
    check("sat_rst_stall", 64'(stall_cycles), 64'd0);
    check("sat_rst_valid", 64'(bus.out_valid), 64'd0);
    check("sat_rst_in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    step();
    check("sat_rel_in_ready", 64'(bus.in_ready), 64'd1);

    // 6a: reset and flush together with an accept in state ONE
    drive(1'b1, 8'h11);
    step();
    check("rf_one_ctrl", 64'(bus.out_ctrl), 64'h11);
    drive(1'b1, 8'h22);
    reset = 1'b1;
    flush = 1'b1;
    step();
    check("rf_valid", 64'(bus.out_valid), 64'd0);
    check("rf_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("rf_data", 64'(bus.out_data), 64'd0);
    check("rf_in_ready", 64'(bus.in_ready), 64'd0);
    check("rf_stall", 64'(stall_cycles), 64'd0);
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 8'h00);
    step();
    check("rf_rel_in_ready", 64'(bus.in_ready), 64'd1);
    check("rf_rel_valid", 64'(bus.out_valid), 64'd0);

    // 6b: flush alone with an accept in state ONE discards the new beat
    drive(1'b1, 8'h33);
    step();
    drive(1'b1, 8'h44);
    flush = 1'b1;
    step();
    check("fa_valid", 64'(bus.out_valid), 64'd0);
    check("fa_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("fa_data", 64'(bus.out_data), 64'd0);
    check("fa_in_ready", 64'(bus.in_ready), 64'd1);
    check("fa_stall", 64'(stall_cycles), 64'd1);
    flush = 1'b0;
    drive(1'b0, 8'h00);
    step();
    check("fa_no_44", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
